video_stream_checker: RTL and testbench

// - Sink-side monitor for the de/pix video stream from the frame generator. It sits on the same pixel clock.
// - Recovers line and frame boundaries from de_i alone; there is no hsync or vsync.
// - Measures the active and total geometry of each frame and checks it against the expected timing.
// - Checks each active pixel against the white inner-border pattern.
// - Reports lock, a per-frame strobe, measured sizes and sticky error flags. Used in simulation and as an on-board self-check.

---
 rtl/video_stream_checker.sv | 171 +++++++++++++++++
 tb/tb_video_stream_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_checker.sv
// Sink-side checker for a de/pix video stream: recovers line/frame edges from de alone,
// measures geometry, checks the white inner-border pattern and reports lock and sticky errors.
module video_stream_checker #(
    parameter logic [10:0] EXP_COL_TOTAL  = 11'd90,
    parameter logic [10:0] EXP_COL_ACTIVE = 11'd80,
    parameter logic [10:0] EXP_ROW_TOTAL  = 11'd70,
    parameter logic [10:0] EXP_ROW_ACTIVE = 11'd60,
    parameter logic [15:0] VBLANK_MIN     = 16'd200
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        de_i,
    input  logic [11:0] pix_i,
    input  logic        clr_i,
    output logic        locked_o,
    output logic        frame_o,
    output logic [10:0] meas_cols_o,
    output logic [10:0] meas_rows_o,
    output logic        err_timing_o,
    output logic        err_pixel_o
);

    localparam logic [23:0] EXP_FRM_TOTAL = 24'(EXP_COL_TOTAL) * 24'(EXP_ROW_TOTAL);

    typedef enum logic [1:0] {SEEK, SYNC, ACTIVE, BLANK} state_t;

    state_t      state_reg;
    logic        de_reg;
    logic        de_d_reg;
    logic [11:0] pix_reg;
    logic        clr_reg;
    logic [15:0] gap_cnt_reg;
    logic [10:0] run_cnt_reg;
    logic [10:0] line_cnt_reg;
    logic [23:0] frm_cnt_reg;
    logic [10:0] lrise_cnt_reg;
    logic        frame_err_reg;
    logic        frame_ok_reg;

    logic        rise;
    logic        fall;
    logic        vertical;
    logic        frame_start;
    logic        frame_end;
    logic        line_start;
    logic [10:0] row_next;
    logic [10:0] col_cur;
    logic [10:0] rows_meas;
    logic        chk_pix;
    logic [11:0] exp_pix;
    logic        pix_err;
    logic        run_err;
    logic        lrise_err;
    logic        edge_err;
    logic        time_err;
    logic        any_err;

    function automatic logic [10:0] inc11(input logic [10:0] v);
        return (&v) ? v : v + 11'd1;
    endfunction

    function automatic logic [15:0] inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [23:0] inc24(input logic [23:0] v);
        return (&v) ? v : v + 24'd1;
    endfunction

    always_comb begin
        rise        = de_reg & ~de_d_reg;
        fall        = ~de_reg & de_d_reg;
        vertical    = rise && (gap_cnt_reg >= VBLANK_MIN);
        frame_end   = (state_reg == BLANK) && vertical;
        frame_start = rise && ((state_reg == SYNC) || frame_end);
        line_start  = rise && (state_reg == BLANK) && !vertical;
        rows_meas   = inc11(line_cnt_reg);

        row_next = line_cnt_reg;
        if (frame_start) begin
            row_next = 11'd0;
        end else if (line_start) begin
            row_next = rows_meas;
        end
        col_cur = rise ? 11'd0 : run_cnt_reg;

        // The rise cycle itself carries column 0, so it is checked before ACTIVE is entered.
        chk_pix = de_reg && ((state_reg == ACTIVE) || frame_start || line_start);
        exp_pix = 12'h000;
        if ((row_next == 11'd0) || (row_next == EXP_ROW_ACTIVE - 11'd1) ||
            (col_cur == 11'd0) || (col_cur == EXP_COL_ACTIVE - 11'd1)) begin
            exp_pix = 12'hfff;
        end
        pix_err = chk_pix && (pix_reg != exp_pix);

        run_err   = (state_reg == ACTIVE) && fall && (run_cnt_reg != EXP_COL_ACTIVE);
        lrise_err = line_start && (lrise_cnt_reg != EXP_COL_TOTAL);
        edge_err  = frame_end && ((rows_meas != EXP_ROW_ACTIVE) || (frm_cnt_reg != EXP_FRM_TOTAL));
        time_err  = run_err | lrise_err | edge_err;
        any_err   = time_err | pix_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= SEEK;
            de_reg        <= 1'b0;
            de_d_reg      <= 1'b0;
            pix_reg       <= 12'h000;
            clr_reg       <= 1'b0;
            gap_cnt_reg   <= 16'd0;
            run_cnt_reg   <= 11'd0;
            line_cnt_reg  <= 11'd0;
            frm_cnt_reg   <= 24'd0;
            lrise_cnt_reg <= 11'd0;
            frame_err_reg <= 1'b0;
            frame_ok_reg  <= 1'b0;
            locked_o      <= 1'b0;
            frame_o       <= 1'b0;
            meas_cols_o   <= 11'd0;
            meas_rows_o   <= 11'd0;
            err_timing_o  <= 1'b0;
            err_pixel_o   <= 1'b0;
        end else begin
            de_reg   <= de_i;
            de_d_reg <= de_reg;
            pix_reg  <= pix_i;
            clr_reg  <= clr_i;

            gap_cnt_reg   <= de_reg ? 16'd0 : inc16(gap_cnt_reg);
            if (de_reg) begin
                run_cnt_reg <= rise ? 11'd1 : inc11(run_cnt_reg);
            end
            lrise_cnt_reg <= rise ? 11'd1 : inc11(lrise_cnt_reg);
            frm_cnt_reg   <= frame_start ? 24'd1 : inc24(frm_cnt_reg);
            line_cnt_reg  <= row_next;

            frame_o <= frame_end;
            if (frame_end) begin
                meas_rows_o <= rows_meas;
                meas_cols_o <= run_cnt_reg;
            end

            // A new error in the same cycle as a clear keeps the flag set.
            err_timing_o <= (err_timing_o & ~clr_reg) | time_err;
            err_pixel_o  <= (err_pixel_o & ~clr_reg) | pix_err;

            // Edge errors belong to the frame that ends; a pixel error on the rise belongs to the new one.
            frame_ok_reg <= !(frame_err_reg || edge_err);
            if (frame_start) begin
                frame_err_reg <= pix_err;
            end else begin
                frame_err_reg <= frame_err_reg | any_err;
            end

            if (any_err) begin
                locked_o <= 1'b0;
            end else if (frame_o && frame_ok_reg) begin
                locked_o <= 1'b1;
            end

            case (state_reg)
                SEEK:    if (gap_cnt_reg == VBLANK_MIN) state_reg <= SYNC;
                SYNC:    if (rise) state_reg <= ACTIVE;
                ACTIVE:  if (fall) state_reg <= BLANK;
                BLANK:   if (rise) state_reg <= ACTIVE;
                default: state_reg <= SEEK;
            endcase
        end
    end

endmodule

// File: tb/tb_video_stream_checker.sv
// Drives whole frames described at line level and scores every frame_o against a
// frame-level model of the geometry, pattern, sticky-flag and lock rules.
module tb_video_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de = 1'b0;
    logic [11:0] pix = 12'h000;
    logic        clr = 1'b0;
    logic        locked;
    logic        frame_s;
    logic [10:0] meas_cols;
    logic [10:0] meas_rows;
    logic        err_t;
    logic        err_p;

    video_stream_checker dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .de_i        (de),
        .pix_i       (pix),
        .clr_i       (clr),
        .locked_o    (locked),
        .frame_o     (frame_s),
        .meas_cols_o (meas_cols),
        .meas_rows_o (meas_rows),
        .err_timing_o(err_t),
        .err_pixel_o (err_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rows;
        int cols;
        bit et;
        bit ep;
        bit lock;
        int period;
    } exp_t;

    typedef struct {
        int          n_act;
        int          odd_row;
        int          odd_len;
        int          gap_row;
        int          pix_row;
        int          pix_col;
        logic [11:0] pix_val;
        bit          clr_gap;
        bit          clr_with_pix;
        int          start_row;
        int          rst_row;
        bit          push;
    } frame_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    bit   have_last = 0;
    bit   lock_pend = 0;
    bit   lock_exp = 0;
    int   n_frames = 0;
    bit   st_t = 0;
    bit   st_p = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [11:0] pattern(input int r, input int c);
        return (r == 0 || r == 59 || c == 0 || c == 79) ? 12'hfff : 12'h000;
    endfunction

    function automatic frame_t clean_frame();
        frame_t f;
        f.n_act = 60;  f.odd_row = -1;  f.odd_len = 80;  f.gap_row = -1;
        f.pix_row = -1; f.pix_col = 0;  f.pix_val = 12'h000;
        f.clr_gap = 0; f.clr_with_pix = 0; f.start_row = 0; f.rst_row = -1; f.push = 1;
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f = clean_frame();
        case ($urandom_range(0, 4))
            1: begin
                f.pix_row = $urandom_range(0, 59);
                f.pix_col = (f.pix_row == 0) ? $urandom_range(2, 79) : $urandom_range(0, 79);
                f.pix_val = pattern(f.pix_row, f.pix_col) ^ 12'($urandom_range(1, 4095));
            end
            2: begin
                f.odd_row = $urandom_range(0, 59);
                f.odd_len = ($urandom_range(0, 1) == 1) ? 79 : 81;
            end
            3: f.gap_row = $urandom_range(0, 58);
            4: f.n_act = ($urandom_range(0, 1) == 1) ? 59 : 61;
            default: ;
        endcase
        f.clr_gap = ($urandom_range(0, 1) == 1);
        return f;
    endfunction

    task automatic drive(input logic d, input logic [11:0] p, input logic c);
        de = d;
        pix = p;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input frame_t f);
        int   len[64];
        int   gap[64];
        int   total;
        bit   line_err;
        bit   edge_err;
        bit   perr;
        bit   bad;
        exp_t e;
        total = 0;
        line_err = 0;
        for (int i = 0; i < f.n_act; i++) begin
            len[i] = (i == f.odd_row) ? f.odd_len : 80;
            gap[i] = 90 - len[i] + ((i == f.gap_row) ? 1 : 0);
            if (i == f.n_act - 1) gap[i] += (70 - f.n_act) * 90;
            total += len[i] + gap[i];
            if (len[i] != 80) line_err = 1;
            if (i < f.n_act - 1 && len[i] + gap[i] != 90) line_err = 1;
        end
        edge_err = (f.n_act != 60) || (total != 6300);
        perr = (f.pix_row >= 0) && (f.pix_val != pattern(f.pix_row, f.pix_col));

        for (int i = f.start_row; i < f.n_act; i++) begin
            for (int c = 0; c < len[i]; c++) begin
                bad = (i == f.pix_row) && (c == f.pix_col);
                if (i == f.rst_row && c == 40) rst_n = 1'b0;
                drive(1'b1, bad ? f.pix_val : pattern(i, c), bad && f.clr_with_pix);
                if (i == f.rst_row && c >= 40 && c <= 42) begin
                    check("reset_outputs", {locked, frame_s, meas_cols, meas_rows, err_t, err_p}, 64'd0);
                    if (c == 42) begin
                        rst_n = 1'b1;
                        st_t = 0;
                        st_p = 0;
                    end
                end
            end
            for (int g = 0; g < gap[i]; g++) begin
                drive(1'b0, 12'h000, f.clr_gap && (i == f.n_act - 1) && (g == 100));
                if (g == 5 && i == f.pix_row && perr) begin
                    check("pix_err_set", err_p, 64'd1);
                    check("lock_drop", locked, 64'd0);
                end
            end
        end

        if (f.push) begin
            if (f.clr_with_pix) st_t = 0;
            st_t = st_t | line_err;
            st_p = st_p | perr;
            if (f.clr_gap) begin
                st_t = 0;
                st_p = 0;
            end
            st_t = st_t | edge_err;
            e.rows = f.n_act;
            e.cols = len[f.n_act - 1];
            e.et = st_t;
            e.ep = st_p;
            e.lock = !(line_err || edge_err || perr);
            e.period = total;
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_last = 0;
            lock_pend = 0;
        end else begin
            if (lock_pend) begin
                check("locked_after_frame", locked, 64'(lock_exp));
                lock_pend = 0;
            end
            if (frame_s) begin
                n_frames++;
                if (exp_q.size() == 0) begin
                    check("spurious_frame", 64'd1, 64'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    $display("frame %0d: rows=%0d cols=%0d err_t=%0d err_p=%0d", n_frames,
                             meas_rows, meas_cols, err_t, err_p);
                    check("meas_rows", meas_rows, 64'(e_mon.rows));
                    check("meas_cols", meas_cols, 64'(e_mon.cols));
                    check("err_timing", err_t, 64'(e_mon.et));
                    check("err_pixel", err_p, 64'(e_mon.ep));
                    if (have_last) check("frame_period", 64'(cyc - last_cyc), 64'(e_mon.period));
                    lock_pend = 1;
                    lock_exp = e_mon.lock;
                end
                last_cyc = cyc;
                have_last = 1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t f;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {locked, frame_s, meas_cols, meas_rows, err_t, err_p}, 64'd0);
        rst_n = 1'b1;

        // Partial frame first: the checker must not report until it has seen a vblank.
        f = clean_frame(); f.start_row = 30; f.push = 0; send_frame(f);
        send_frame(clean_frame());
        send_frame(clean_frame());
        f = clean_frame(); f.pix_row = 0; f.pix_col = 5; f.pix_val = 12'h000; send_frame(f);
        send_frame(clean_frame());
        f = clean_frame(); f.clr_gap = 1; send_frame(f);
        f = clean_frame(); f.odd_row = 20; f.odd_len = 79; send_frame(f);
        f = clean_frame(); f.n_act = 59; send_frame(f);
        f = clean_frame(); f.pix_row = 10; f.pix_col = 0; f.pix_val = 12'h000; f.clr_with_pix = 1;
        send_frame(f);
        send_frame(rand_frame());
        send_frame(rand_frame());
        f = clean_frame(); f.rst_row = 30; f.push = 0; send_frame(f);
        send_frame(clean_frame());
        send_frame(clean_frame());

        // Start one more frame so the last queued frame gets its frame_o.
        for (int c = 0; c < 3; c++) drive(1'b1, pattern(0, c), 1'b0);
        repeat (20) drive(1'b0, 12'h000, 1'b0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("frame_count", 64'(n_frames), 64'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
